regfile_mp: RTL and testbench

//  Multi-ported integer register file for the pipeline: NUM_READ combinational read ports, NUM_WRITE

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizing defaults and address/data types for the integer register file.
package rf_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  function automatic int addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

  localparam int AW_DEF = addr_width(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set when a producer issues, cleared at its writeback,
// wiped on flush. Busy lookup masks registers being written back this cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG      = NREG_DEF,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_READ*AW-1:0]  read_addr,
  input  logic [NUM_WRITE*AW-1:0] write_addr,
  input  logic [NUM_WRITE-1:0]    write_ena,
  input  logic                    issue_ena,
  input  logic [AW-1:0]           issue_addr,
  input  logic                    flush,
  output logic [NUM_READ-1:0]     read_busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Issue is applied after writeback clears so a new producer stays outstanding.
  always_comb begin
    pending_nxt = pending;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (write_ena[j]) pending_nxt[write_addr[j*AW +: AW]] = 1'b0;
    end
    if (issue_ena) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy
    logic [AW-1:0] ra;
    logic          wb_hit;

    assign ra = read_addr[i*AW +: AW];

    always_comb begin
      wb_hit = 1'b0;
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (write_ena[j] && (write_addr[j*AW +: AW] == ra)) wb_hit = 1'b1;
      end
    end

    assign read_busy[i] = (ra != '0) && pending[ra] && !wb_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file: x0 hardwired to zero, write-to-read bypass,
// sticky flag for writes aimed at x0, and a RAW-hazard scoreboard for decode.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_READ*AW-1:0]    read_addr,
  output logic [NUM_READ*XLEN-1:0]  read_data,
  output logic [NUM_READ-1:0]       read_busy,
  input  logic [NUM_WRITE*AW-1:0]   write_addr,
  input  logic [NUM_WRITE*XLEN-1:0] write_data,
  input  logic [NUM_WRITE-1:0]      write_ena,
  input  logic                      issue_ena,
  input  logic [AW-1:0]             issue_addr,
  input  logic                      flush,
  output logic                      x0_write
);

  logic [XLEN-1:0] regs [NREG];

  // Later loop iterations override earlier ones, so the highest port index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      x0_write <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (write_ena[j]) begin
          if (write_addr[j*AW +: AW] != '0) begin
            regs[write_addr[j*AW +: AW]] <= write_data[j*XLEN +: XLEN];
          end else begin
            x0_write <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = read_addr[i*AW +: AW];

    always_comb begin
      rd = regs[ra];
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (write_ena[j] && (write_addr[j*AW +: AW] == ra)) rd = write_data[j*XLEN +: XLEN];
      end
      if (ra == '0) rd = '0;
    end

    assign read_data[i*XLEN +: XLEN] = rd;
  end

  rf_scoreboard #(
    .NREG      (NREG),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .read_addr  (read_addr),
    .write_addr (write_addr),
    .write_ena  (write_ena),
    .issue_ena  (issue_ena),
    .issue_addr (issue_addr),
    .flush      (flush),
    .read_busy  (read_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with two write ports: vector table plus a
// randomized write/readback sequence, expectations queued and popped at negedge.
module tb_regfile_mp;
  import rf_pkg::*;

  logic          clk;
  logic          rst;
  logic [9:0]    read_addr;
  logic [127:0]  read_data;
  logic [1:0]    read_busy;
  logic [9:0]    write_addr;
  logic [127:0]  write_data;
  logic [1:0]    write_ena;
  logic          issue_ena;
  logic [4:0]    issue_addr;
  logic          flush;
  logic          x0_write;

  regfile_mp #(.NUM_READ(2), .NUM_WRITE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_busy  (read_busy),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_ena  (write_ena),
    .issue_ena  (issue_ena),
    .issue_addr (issue_addr),
    .flush      (flush),
    .x0_write   (x0_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      rst;
    reg_addr_t ra0, ra1;
    logic [1:0] we;
    reg_addr_t wa0, wa1;
    xdata_t    wd0, wd1;
    logic      ie;
    reg_addr_t ia;
    logic      fl;
    xdata_t    e0, e1;
    logic [1:0] eb;
    logic      ex0;
  } vec_t;

  typedef struct {
    xdata_t     e0, e1;
    logic [1:0] eb;
    logic       ex0;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  xdata_t model [32];

  function automatic vec_t mk(input logic r, input reg_addr_t ra0, input reg_addr_t ra1,
                              input logic [1:0] we, input reg_addr_t wa0, input xdata_t wd0,
                              input reg_addr_t wa1, input xdata_t wd1,
                              input logic ie, input reg_addr_t ia, input logic fl,
                              input xdata_t e0, input xdata_t e1, input logic [1:0] eb,
                              input logic ex0);
    vec_t v;
    v.rst = r; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wd0 = wd0;
    v.wa1 = wa1; v.wd1 = wd1; v.ie = ie; v.ia = ia; v.fl = fl;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ex0 = ex0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    read_addr  = {v.ra1, v.ra0};
    write_ena  = v.we;
    write_addr = {v.wa1, v.wa0};
    write_data = {v.wd1, v.wd0};
    issue_ena  = v.ie;
    issue_addr = v.ia;
    flush      = v.fl;
    exp_q.push_back('{e0: v.e0, e1: v.e1, eb: v.eb, ex0: v.ex0});
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    @(negedge clk);
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      if (read_data[63:0] !== e.e0 || read_data[127:64] !== e.e1 ||
          read_busy !== e.eb || x0_write !== e.ex0) begin
        tests_failed++;
        $display("[TB] FAIL %s: got rd0=%h rd1=%h busy=%b x0w=%b, want rd0=%h rd1=%h busy=%b x0w=%b",
                 name, read_data[63:0], read_data[127:64], read_busy, x0_write,
                 e.e0, e.e1, e.eb, e.ex0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    reg_addr_t a0, a1;

    rst = 1'b1; read_addr = '0; write_addr = '0; write_data = '0; write_ena = '0;
    issue_ena = 1'b0; issue_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: every register reads zero on both ports, nothing busy.
    for (int r = 0; r < 32; r++) begin
      a0 = reg_addr_t'(r);
      a1 = reg_addr_t'(31 - r);
      applyStimulus(mk(0, a0, a1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
      checkOutput($sformatf("reset_read_%0d", r));
    end

    //              rst ra0 ra1 we     wa0 wd0              wa1 wd1  ie ia fl  e0               e1               eb     x0
    tbl.push_back(mk(0, 5,  0,  2'b01, 5,  64'hDEAD_BEEF,   0,  0,   0, 0, 0, 64'hDEAD_BEEF,   0,               2'b00, 0));
    tbl.push_back(mk(0, 5,  5,  2'b00, 0,  0,               0,  0,   0, 0, 0, 64'hDEAD_BEEF,   64'hDEAD_BEEF,   2'b00, 0));
    tbl.push_back(mk(0, 7,  5,  2'b11, 7,  1,               7,  2,   0, 0, 0, 2,               64'hDEAD_BEEF,   2'b00, 0));
    tbl.push_back(mk(0, 7,  7,  2'b00, 0,  0,               0,  0,   0, 0, 0, 2,               2,               2'b00, 0));
    tbl.push_back(mk(0, 0,  0,  2'b01, 0,  64'h1234,        0,  0,   0, 0, 0, 0,               0,               2'b00, 0));
    tbl.push_back(mk(0, 0,  7,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               2,               2'b00, 1));
    tbl.push_back(mk(0, 3,  0,  2'b00, 0,  0,               0,  0,   1, 3, 0, 0,               0,               2'b00, 1));
    tbl.push_back(mk(0, 3,  3,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b11, 1));
    tbl.push_back(mk(0, 3,  3,  2'b01, 3,  9,               0,  0,   0, 0, 0, 9,               9,               2'b00, 1));
    tbl.push_back(mk(0, 3,  3,  2'b00, 0,  0,               0,  0,   0, 0, 0, 9,               9,               2'b00, 1));
    tbl.push_back(mk(0, 4,  0,  2'b10, 0,  0,               4,  44,  1, 4, 0, 44,              0,               2'b00, 1));
    tbl.push_back(mk(0, 4,  0,  2'b00, 0,  0,               0,  0,   0, 0, 0, 44,              0,               2'b01, 1));
    tbl.push_back(mk(0, 6,  4,  2'b00, 0,  0,               0,  0,   1, 6, 1, 0,               44,              2'b10, 1));
    tbl.push_back(mk(0, 6,  4,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               44,              2'b00, 1));
    tbl.push_back(mk(0, 8,  0,  2'b00, 0,  0,               0,  0,   1, 8, 0, 0,               0,               2'b00, 1));
    tbl.push_back(mk(0, 8,  9,  2'b00, 0,  0,               0,  0,   1, 9, 0, 0,               0,               2'b01, 1));
    tbl.push_back(mk(0, 8,  9,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b11, 1));
    tbl.push_back(mk(1, 8,  9,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b11, 1));
    tbl.push_back(mk(0, 8,  9,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b00, 0));
    tbl.push_back(mk(0, 5,  7,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b00, 0));
    tbl.push_back(mk(0, 0,  0,  2'b00, 0,  0,               0,  0,   1, 0, 0, 0,               0,               2'b00, 0));
    tbl.push_back(mk(0, 0,  0,  2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b00, 0));
    tbl.push_back(mk(0, 10, 0,  2'b00, 0,  0,               0,  0,   1, 10, 0, 0,              0,               2'b00, 0));
    tbl.push_back(mk(0, 10, 0,  2'b00, 0,  0,               0,  0,   1, 10, 0, 0,              0,               2'b01, 0));
    tbl.push_back(mk(0, 10, 10, 2'b00, 0,  0,               0,  0,   0, 0, 0, 0,               0,               2'b11, 0));

    foreach (tbl[k]) begin
      applyStimulus(tbl[k]);
      checkOutput($sformatf("vec_%0d", k));
    end

    // Randomized writes on both ports into a reference array, then full readback.
    flush = 1'b1;
    issue_ena = 1'b0;
    write_ena = '0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int r = 0; r < 32; r++) model[r] = '0;
    for (int c = 0; c < 40; c++) begin
      v = mk(0, 0, 0, 2'($urandom_range(0, 3)),
             reg_addr_t'($urandom_range(1, 31)), {$urandom, $urandom},
             reg_addr_t'($urandom_range(1, 31)), {$urandom, $urandom},
             0, 0, 0, 0, 0, 2'b00, 0);
      if (v.we[0]) model[v.wa0] = v.wd0;
      if (v.we[1]) model[v.wa1] = v.wd1;
      rst = 1'b0; read_addr = '0; issue_ena = 1'b0; flush = 1'b0;
      write_ena = v.we; write_addr = {v.wa1, v.wa0}; write_data = {v.wd1, v.wd0};
      @(posedge clk);
      #1;
    end
    for (int r = 0; r < 32; r++) begin
      a0 = reg_addr_t'(r);
      a1 = reg_addr_t'((r * 7) % 32);
      applyStimulus(mk(0, a0, a1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                       model[a0], model[a1], 2'b00, 0));
      checkOutput($sformatf("rand_readback_%0d", r));
    end

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
